oai222_bist_ctrl: RTL and testbench
===================================

# oai222_bist_ctrl

Built-in self-test sequencer for one instance of the 2-2-2 OR-AND-INVERT cell (function ZN = !((A1|A2)&(B1|B2)&(C1|C2))). On START it drives all 64 input patterns onto the cell. After a programmable settle time it samples ZN, compares it against a golden model and reports a pass/fail summary. It sits in the library characterisation/test-chip wrapper between the scan-accessible control register and the cell under test.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: extra cycles each vector is held before ZN is sampled; legal range 0..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RN  in  1  reset; synchronous, active-low.
- START  in  1  begin a run; honoured only in IDLE.
- ABORT  in  1  terminate a run; honoured in any non-IDLE state.
- ZN  in  1  output of the cell under test.
- A1, A2, B1, B2, C1, C2  out  1 each  registered stimulus to the cell; VEC[5:0] = {A1,A2,B1,B2,C1,C2}.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  one-cycle pulse when a run completes normally.
- PASS  out  1  high after a completed run with zero mismatches.
- ERR_CNT  out  7  number of mismatching vectors in the last run (0..64).
- FAIL_VALID  out  1  at least one mismatch has been logged.
- FIRST_FAIL  out  6  VEC value of the first mismatch.

## Operation
- Reset (RN=0 at an edge) sets:
  - state IDLE;
  - VEC=0;
  - BUSY=0, DONE=0, PASS=0;
  - ERR_CNT=0, FAIL_VALID=0, FIRST_FAIL=0.
- States: IDLE, APPLY, SETTLE, CHECK, FINISH.
- IDLE:
  - START=1 → APPLY.
  - VEC, ERR_CNT, FAIL_VALID, FIRST_FAIL and PASS are cleared on this edge.
- APPLY:
  - VEC holds the current vector.
  - Go to SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE:
  - Settle counter counts to SETTLE_CYCLES-1, then → CHECK.
- CHECK:
  - ZN is compared against the expected value, oai222_ref(VEC).
  - On mismatch, ERR_CNT increments.
  - On the first mismatch, FIRST_FAIL=VEC and FAIL_VALID=1.
  - If VEC==63 → FINISH; else VEC increments and the next state is APPLY.
- FINISH:
  - DONE=1 for this single cycle.
  - PASS=(ERR_CNT==0).
  - → IDLE.
- Mismatch definition: in simulation, any ZN value other than the expected one, including X or Z, is a mismatch (4-state compare).
- ABORT (any non-IDLE state) → IDLE on the next edge:
  - BUSY=0, DONE not pulsed, PASS=0;
  - VEC=0;
  - ERR_CNT, FAIL_VALID and FIRST_FAIL keep their partial values.
- ABORT has priority over every other transition. START while busy is ignored.
- Results persist in IDLE until the next accepted START or reset.
- ERR_CNT never exceeds 64, so no saturation logic is needed.

## Timing
- START is sampled at edge k. From cycle k+1, BUSY=1 and VEC=0 are driven.
- Each vector occupies SETTLE_CYCLES+1 cycles: one APPLY cycle plus SETTLE_CYCLES settle cycles. ZN is sampled at the end of the last of these cycles.
  - The CHECK action is merged into that final cycle.
  - The comparison happens on the same edge where VEC advances.
- Vector n is driven during cycles k+1+n*(S+1) through k+(n+1)*(S+1), where S=SETTLE_CYCLES.
- DONE pulses in cycle k+64*(S+1)+1. BUSY falls in the same cycle as DONE.
- PASS and the final ERR_CNT are valid from the DONE cycle onward.
- Reset mid-run:
  - the synchronous reset wins over START and ABORT;
  - all outputs return to their reset values on that edge.
- Stimulus outputs change only on CLK edges, so there is no glitch path from control inputs.

## Structure
- Package oai222_bist_pkg contains:
  - the state enum;
  - VEC_W=6, NUM_VEC=64, ERR_W=7;
  - function oai222_ref(input [5:0] v), returning !((v[5]|v[4])&(v[3]|v[2])&(v[1]|v[0])).
- Single module, no sub-module. The settle counter and vector counter are inline registers.
- The cell under test is instantiated by the wrapper, not inside this block.

## Test plan
- Correct cell model, S=2: START pulse → DONE at START-edge+193 cycles, PASS=1, ERR_CNT=0, FAIL_VALID=0.
- ZN stuck at 1, S=2 → ERR_CNT=27, FIRST_FAIL=6'b010101 (21), PASS=0.
- ZN stuck at 0, S=0 → ERR_CNT=37, FIRST_FAIL=0, DONE at START-edge+65.
- Model driving ZN=!expected → ERR_CNT=64, FIRST_FAIL=0. Then a second START clears ERR_CNT to 0 on the accept edge.
- ABORT during vector 10, stuck-at-1 ZN → BUSY=0 next cycle, no DONE, PASS=0, ERR_CNT=0, FAIL_VALID=0 (first expected-0 vector is 21). RN=0 during vector 30 → all outputs at reset values after that edge.
- START held high for the whole run → exactly one run, then a new run starts from IDLE on the edge after FINISH. START asserted while BUSY → ignored, timing unchanged.

Source files
------------

// File: rtl/oai222_bist_ctrl_pkg.sv
// Shared types, sizes and the golden OAI222 model for the BIST sequencer.
package oai222_bist_pkg;

    localparam int VEC_W   = 6;
    localparam int NUM_VEC = 64;
    localparam int ERR_W   = 7;

    // S_CHECK names the compare step; it is folded into the last hold cycle of each vector.
    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_FINISH
    } state_t;

    function automatic logic oai222_ref(input logic [5:0] v);
        return !((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
    endfunction

endpackage

// File: rtl/oai222_bist_ctrl.sv
// Exhaustive 64-vector BIST sequencer for a single OAI222 cell: drives stimulus,
// waits SETTLE_CYCLES, compares ZN to the golden model and keeps a fail summary.
module oai222_bist_ctrl
    import oai222_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    input  logic             ZN,
    output logic             A1,
    output logic             A2,
    output logic             B1,
    output logic             B2,
    output logic             C1,
    output logic             C2,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VALID,
    output logic [VEC_W-1:0] FIRST_FAIL
);

    localparam int               SL       = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [3:0]       SET_LAST = SL[3:0];
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [3:0]       cnt;
    logic             last_slot;
    logic             mismatch;
    logic [ERR_W-1:0] err_nxt;

    assign {A1, A2, B1, B2, C1, C2} = vec;

    // Final hold cycle of the current vector: compare and advance on its closing edge.
    assign last_slot = (state == S_APPLY && SETTLE_CYCLES == 0) ||
                       (state == S_SETTLE && cnt == SET_LAST);
    // 4-state compare so X/Z from the cell counts as a failure in simulation.
    assign mismatch  = (ZN !== oai222_ref(vec));
    assign err_nxt   = ERR_CNT + ERR_W'(mismatch);

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state      <= S_IDLE;
            vec        <= '0;
            cnt        <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VALID <= 1'b0;
            FIRST_FAIL <= '0;
        end else if (ABORT && state != S_IDLE) begin
            state <= S_IDLE;
            vec   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state      <= S_APPLY;
                        vec        <= '0;
                        cnt        <= '0;
                        BUSY       <= 1'b1;
                        PASS       <= 1'b0;
                        ERR_CNT    <= '0;
                        FAIL_VALID <= 1'b0;
                        FIRST_FAIL <= '0;
                    end
                end
                S_APPLY, S_SETTLE: begin
                    if (last_slot) begin
                        ERR_CNT <= err_nxt;
                        if (mismatch && !FAIL_VALID) begin
                            FIRST_FAIL <= vec;
                            FAIL_VALID <= 1'b1;
                        end
                        if (vec == VEC_LAST) begin
                            state <= S_FINISH;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            PASS  <= (err_nxt == '0);
                        end else begin
                            vec   <= vec + 1'b1;
                            state <= S_APPLY;
                        end
                    end else if (state == S_APPLY) begin
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oai222_bist_ctrl.sv
// Directed bench: two sequencers (settle 2 and settle 0) driven against a behavioural cell model.
module tb_oai222_bist_ctrl;

    logic CLK = 1'b0;
    logic RN  = 1'b0;
    always #5 CLK = ~CLK;

    logic start0 = 1'b0, abort0 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    int   zm0 = 0, zm2 = 0;
    logic zn0, zn2;
    wire  [5:0] v0, v2;
    logic busy0, done0, pass0, fv0, busy2, done2, pass2, fv2;
    logic [6:0] ec0, ec2;
    logic [5:0] ff0, ff2;

    int checks = 0;
    int errors = 0;

    // Cell models: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 inverted
    function automatic logic zn_model(input int m, input logic [5:0] v);
        logic good;
        good = ~((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
        case (m)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ~good;
            default: return good;
        endcase
    endfunction

    assign zn0 = zn_model(zm0, v0);
    assign zn2 = zn_model(zm2, v2);

    oai222_bist_ctrl #(.SETTLE_CYCLES(2)) u2 (
        .CLK(CLK), .RN(RN), .START(start2), .ABORT(abort2), .ZN(zn2),
        .A1(v2[5]), .A2(v2[4]), .B1(v2[3]), .B2(v2[2]), .C1(v2[1]), .C2(v2[0]),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(ec2),
        .FAIL_VALID(fv2), .FIRST_FAIL(ff2)
    );

    oai222_bist_ctrl #(.SETTLE_CYCLES(0)) u0 (
        .CLK(CLK), .RN(RN), .START(start0), .ABORT(abort0), .ZN(zn0),
        .A1(v0[5]), .A2(v0[4]), .B1(v0[3]), .B2(v0[2]), .C1(v0[1]), .C2(v0[0]),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(ec0),
        .FAIL_VALID(fv0), .FIRST_FAIL(ff0)
    );

    logic       sel2 = 1'b1;
    logic [5:0] sv, sff;
    logic       sb, sd, sp, sf;
    logic [6:0] se;

    always_comb begin
        sv = v0; sb = busy0; sd = done0; sp = pass0; sf = fv0; se = ec0; sff = ff0;
        if (sel2) begin
            sv = v2; sb = busy2; sd = done2; sp = pass2; sf = fv2; se = ec2; sff = ff2;
        end
    end

    typedef struct {
        logic       s2;
        int         zm;
        int         lat;
        logic [6:0] ec;
        logic [5:0] ff;
        logic       fv;
        logic       pass;
    } run_t;

    run_t runs[5];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel2) start2 = v; else start0 = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel2) abort2 = v; else abort0 = v;
    endtask

    task automatic set_zm(input int m);
        if (sel2) zm2 = m; else zm0 = m;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sd && n < 3000);
    endtask

    task automatic wait_vec(input logic [5:0] t);
        int n;
        n = 0;
        while (sv !== t && n < 1000) begin
            tick();
            n++;
        end
        chk("wait_vec", 32'(sv), 32'(t));
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_vec"},  32'(sv),  32'(0));
        chk({nm, "_busy"}, 32'(sb),  32'(0));
        chk({nm, "_done"}, 32'(sd),  32'(0));
        chk({nm, "_pass"}, 32'(sp),  32'(0));
        chk({nm, "_ec"},   32'(se),  32'(0));
        chk({nm, "_fv"},   32'(sf),  32'(0));
        chk({nm, "_ff"},   32'(sff), 32'(0));
    endtask

    initial begin
        int lat;
        int seen;

        runs[0] = '{1'b1, 0, 192, 7'd0,  6'd0,  1'b0, 1'b1};
        runs[1] = '{1'b1, 1, 192, 7'd27, 6'd21, 1'b1, 1'b0};
        runs[2] = '{1'b0, 2, 64,  7'd37, 6'd0,  1'b1, 1'b0};
        runs[3] = '{1'b0, 0, 64,  7'd0,  6'd0,  1'b0, 1'b1};
        runs[4] = '{1'b1, 3, 192, 7'd64, 6'd0,  1'b1, 1'b0};

        RN = 1'b0;
        tick();
        tick();
        sel2 = 1'b1; chk_reset("rst2");
        sel2 = 1'b0; chk_reset("rst0");
        RN = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            sel2 = runs[i].s2;
            set_zm(runs[i].zm);
            set_start(1'b1);
            tick();
            set_start(1'b0);
            chk($sformatf("r%0d_busy_acc", i), 32'(sb), 32'(1));
            chk($sformatf("r%0d_vec_acc", i),  32'(sv), 32'(0));
            chk($sformatf("r%0d_ec_acc", i),   32'(se), 32'(0));
            wait_done(lat);
            chk($sformatf("r%0d_lat", i),       32'(lat), 32'(runs[i].lat));
            chk($sformatf("r%0d_busy_done", i), 32'(sb),  32'(0));
            chk($sformatf("r%0d_ec", i),        32'(se),  32'(runs[i].ec));
            chk($sformatf("r%0d_ff", i),        32'(sff), 32'(runs[i].ff));
            chk($sformatf("r%0d_fv", i),        32'(sf),  32'(runs[i].fv));
            chk($sformatf("r%0d_pass", i),      32'(sp),  32'(runs[i].pass));
            tick();
            chk($sformatf("r%0d_done_pulse", i), 32'(sd), 32'(0));
            chk($sformatf("r%0d_pass_hold", i),  32'(sp), 32'(runs[i].pass));
            chk($sformatf("r%0d_ec_hold", i),    32'(se), 32'(runs[i].ec));
        end

        // Restart after an all-fail run, then abort at vector 10 with stuck-at-1 cell
        sel2 = 1'b1;
        set_zm(1);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        chk("restart_ec", 32'(se), 32'(0));
        chk("restart_fv", 32'(sf), 32'(0));
        wait_vec(6'd10);
        set_abort(1'b1);
        tick();
        set_abort(1'b0);
        chk("abort10_busy", 32'(sb), 32'(0));
        chk("abort10_done", 32'(sd), 32'(0));
        chk("abort10_pass", 32'(sp), 32'(0));
        chk("abort10_vec",  32'(sv), 32'(0));
        chk("abort10_ec",   32'(se), 32'(0));
        chk("abort10_fv",   32'(sf), 32'(0));
        seen = 0;
        for (int c = 0; c < 250; c++) begin
            tick();
            if (sd || sb) seen++;
        end
        chk("abort10_quiet", 32'(seen), 32'(0));

        // Abort at vector 30 keeps partial results (vectors 21,22,23,25,26,27,29 failed)
        set_start(1'b1);
        tick();
        set_start(1'b0);
        wait_vec(6'd30);
        set_abort(1'b1);
        tick();
        set_abort(1'b0);
        chk("abort30_busy", 32'(sb),  32'(0));
        chk("abort30_ec",   32'(se),  32'(7));
        chk("abort30_ff",   32'(sff), 32'(21));
        chk("abort30_fv",   32'(sf),  32'(1));
        chk("abort30_pass", 32'(sp),  32'(0));

        // Reset at vector 30 beats START and ABORT
        set_start(1'b1);
        tick();
        set_start(1'b0);
        wait_vec(6'd30);
        RN = 1'b0;
        start2 = 1'b1;
        abort2 = 1'b1;
        tick();
        chk_reset("midrst2");
        sel2 = 1'b0;
        chk("midrst0_pass", 32'(sp), 32'(0));
        sel2 = 1'b1;
        RN = 1'b1;
        start2 = 1'b0;
        abort2 = 1'b0;
        tick();
        chk("midrst_idle", 32'(sb), 32'(0));

        // START held through a whole settle-0 run
        sel2 = 1'b0;
        set_zm(0);
        set_start(1'b1);
        tick();
        chk("held_busy", 32'(sb), 32'(1));
        wait_done(lat);
        chk("held_lat",  32'(lat), 32'(64));
        chk("held_pass", 32'(sp),  32'(1));
        tick();
        chk("held_idle_busy", 32'(sb), 32'(0));
        chk("held_idle_done", 32'(sd), 32'(0));
        tick();
        chk("held_rerun_busy", 32'(sb), 32'(1));
        chk("held_rerun_vec",  32'(sv), 32'(0));
        set_start(1'b0);
        set_abort(1'b1);
        tick();
        set_abort(1'b0);
        chk("held_abort_busy", 32'(sb), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
